instruction_fetch_stage: RTL

//   Fetch stage directly upstream of the instruction memory: owns the PC register, drives

---
 rtl/instruction_fetch_stage_if.sv | 37 +++
 rtl/instruction_fetch_stage.sv | 114 +++++++++++
 2 files changed

// File: rtl/instruction_fetch_stage_if.sv
// Fetch-stage bus bundle: hazard/branch inputs, instruction memory port and IF/ID outputs.
// FETCH_PERF_COUNTERS_EN adds the fetch/stall counter outputs.
interface instruction_fetch_stage_if;
    logic        i_stall;
    logic        i_branch_taken;
    logic [31:0] i_branch_target;
    logic [31:0] i_instruction;
    logic [31:0] o_read_address;
    logic [31:0] o_ifid_pc;
    logic [31:0] o_ifid_instruction;
    logic        o_ifid_valid;
    logic        o_halted;
    logic        o_misaligned;
`ifdef FETCH_PERF_COUNTERS_EN
    logic [31:0] o_fetch_count;
    logic [31:0] o_stall_count;
`endif

    // master is the fetch stage itself; slave is the surrounding pipeline/memory.
    modport master (
        input  i_stall, i_branch_taken, i_branch_target, i_instruction,
        output o_read_address, o_ifid_pc, o_ifid_instruction, o_ifid_valid,
               o_halted, o_misaligned
`ifdef FETCH_PERF_COUNTERS_EN
        , output o_fetch_count, o_stall_count
`endif
    );

    modport slave (
        output i_stall, i_branch_taken, i_branch_target, i_instruction,
        input  o_read_address, o_ifid_pc, o_ifid_instruction, o_ifid_valid,
               o_halted, o_misaligned
`ifdef FETCH_PERF_COUNTERS_EN
        , input o_fetch_count, o_stall_count
`endif
    );
endinterface

// File: rtl/instruction_fetch_stage.sv
// PC + IF/ID register; zero-latency memory read, IF/ID updates on the edge after ReadAddress.
// Stall holds PC and IF/ID; branches redirect and flush. FETCH_PERF_COUNTERS_EN adds counters.
module instruction_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_WORDS = 32,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    instruction_fetch_stage_if.master   bus
);

    localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * 4);
    localparam logic [31:0] LAST_PC   = 32'((MEM_WORDS - 1) * 4);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_ifid_pc;
    logic [31:0] r_ifid_instruction;
    logic        r_ifid_valid;
    logic        r_halted;
    logic        r_misaligned;
`ifdef FETCH_PERF_COUNTERS_EN
    logic [31:0] r_fetch_count;
    logic [31:0] r_stall_count;
`endif

    logic w_target_legal;
    logic w_at_last;

    assign w_target_legal = (bus.i_branch_target[1:0] == 2'b00) &&
                            (bus.i_branch_target < MEM_BYTES);
    assign w_at_last      = (r_pc == LAST_PC);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state            <= ST_BOOT;
            r_pc               <= RESET_PC;
            r_ifid_pc          <= 32'h0;
            r_ifid_instruction <= NOP_INSTR;
            r_ifid_valid       <= 1'b0;
            r_halted           <= 1'b0;
            r_misaligned       <= 1'b0;
`ifdef FETCH_PERF_COUNTERS_EN
            r_fetch_count      <= 32'h0;
            r_stall_count      <= 32'h0;
`endif
        end else begin
            case (r_state)
                ST_BOOT: begin
                    r_state <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (bus.i_branch_taken) begin
                        r_ifid_instruction <= NOP_INSTR;
                        r_ifid_valid       <= 1'b0;
                        if (w_target_legal) begin
                            r_pc <= bus.i_branch_target;
                        end else begin
                            r_misaligned <= 1'b1;
                            r_halted     <= 1'b1;
                            r_state      <= ST_HALT;
                        end
                    end else if (bus.i_stall) begin
`ifdef FETCH_PERF_COUNTERS_EN
                        r_stall_count <= r_stall_count + 32'd1;
`endif
                    end else begin
                        r_ifid_pc          <= r_pc;
                        r_ifid_instruction <= bus.i_instruction;
                        r_ifid_valid       <= 1'b1;
`ifdef FETCH_PERF_COUNTERS_EN
                        r_fetch_count      <= r_fetch_count + 32'd1;
`endif
                        // The last word is delivered, then the PC parks on it.
                        if (w_at_last) begin
                            r_halted <= 1'b1;
                            r_state  <= ST_HALT;
                        end else begin
                            r_pc <= r_pc + 32'd4;
                        end
                    end
                end
                ST_HALT: begin
                    if (!bus.i_stall) begin
                        r_ifid_instruction <= NOP_INSTR;
                        r_ifid_valid       <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_BOOT;
                end
            endcase
        end
    end

    assign bus.o_read_address     = r_pc;
    assign bus.o_ifid_pc          = r_ifid_pc;
    assign bus.o_ifid_instruction = r_ifid_instruction;
    assign bus.o_ifid_valid       = r_ifid_valid;
    assign bus.o_halted           = r_halted;
    assign bus.o_misaligned       = r_misaligned;
`ifdef FETCH_PERF_COUNTERS_EN
    assign bus.o_fetch_count      = r_fetch_count;
    assign bus.o_stall_count      = r_stall_count;
`endif

endmodule
